// File: rtl/power_energy_alarm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : power_energy_alarm_chan
//  Purpose  : Debounced single-channel alarm FSM. It advances only on
//             strobe cycles. ALARM_COUNT consecutive qualifying samples are
//             needed to enter or to leave the alarm condition.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_strobe      - sample-valid pulse
//             i_over        - this sample is over the limit
//             o_alarm       - registered debounced alarm
//  Revision : 1.0 - initial release
// ============================================================================
module power_energy_alarm_chan #(
    parameter int ALARM_COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_strobe,
    input  logic i_over,
    output logic o_alarm
);

    localparam logic [1:0] c_st_ok       = 2'd0;
    localparam logic [1:0] c_st_pend_on  = 2'd1;
    localparam logic [1:0] c_st_alarm    = 2'd2;
    localparam logic [1:0] c_st_pend_off = 2'd3;

    localparam logic [3:0] c_alarm_cnt = 4'(ALARM_COUNT);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 4'd1;

    // The alarm flag is computed together with the next state, so it
    // changes on the same edge that samples the qualifying strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_ok;
            r_cnt   <= 4'd0;
            o_alarm <= 1'b0;
        end else if (i_strobe) begin
            case (r_state)
                c_st_ok: begin
                    if (i_over) begin
                        if (c_alarm_cnt == 4'd1) begin
                            r_state <= c_st_alarm;
                            r_cnt   <= 4'd0;
                            o_alarm <= 1'b1;
                        end else begin
                            r_state <= c_st_pend_on;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                c_st_pend_on: begin
                    if (i_over) begin
                        if (w_cnt_inc == c_alarm_cnt) begin
                            r_state <= c_st_alarm;
                            r_cnt   <= 4'd0;
                            o_alarm <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_state <= c_st_ok;
                        r_cnt   <= 4'd0;
                    end
                end
                c_st_alarm: begin
                    if (!i_over) begin
                        if (c_alarm_cnt == 4'd1) begin
                            r_state <= c_st_ok;
                            r_cnt   <= 4'd0;
                            o_alarm <= 1'b0;
                        end else begin
                            r_state <= c_st_pend_off;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                default: begin // c_st_pend_off: alarm still shown while clearing
                    if (!i_over) begin
                        if (w_cnt_inc == c_alarm_cnt) begin
                            r_state <= c_st_ok;
                            r_cnt   <= 4'd0;
                            o_alarm <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_state <= c_st_alarm;
                        r_cnt   <= 4'd0;
                    end
                end
            endcase
        end
    end

endmodule

// ============================================================================
//  Module   : power_energy_alarm
//  Purpose  : Consumes Bus_Voltage / Current / Power sample sets from the
//             I2C power monitor. Raises debounced over-current and
//             over-voltage alarms, flags stale input, and integrates Power
//             into a saturating kWh counter.
//  Ports    : CLK_24        - 24 MHz system clock
//             RESET         - synchronous active-high reset
//             SAMPLE_STB    - one-cycle pulse, sample inputs valid
//             Bus_Voltage   - unsigned bus voltage code
//             Current       - two's-complement current code
//             Power         - unsigned power code
//             CURRENT_LIMIT - magnitude limit, 0 disables the channel
//             VOLTAGE_LIMIT - voltage limit, 0 disables the channel
//             ENERGY_CLR    - level, clears accumulator and KW_HR
//             CURRENT_ALARM - debounced over-current
//             VOLTAGE_ALARM - debounced over-voltage
//             ALL_ALARM     - CURRENT_ALARM | VOLTAGE_ALARM | STALE
//             STALE         - no sample within STALE_TICKS ticks
//             KW_HR         - energy count, saturates at 16'hFFFF
//  Revision : 1.0 - initial release
// ============================================================================
module power_energy_alarm #(
    parameter int TICK_DIV    = 24000000,
    parameter int UNIT_COUNT  = 144000000,
    parameter int ALARM_COUNT = 4,
    parameter int STALE_TICKS = 3
) (
    input  logic        CLK_24,
    input  logic        RESET,
    input  logic        SAMPLE_STB,
    input  logic [15:0] Bus_Voltage,
    input  logic [15:0] Current,
    input  logic [15:0] Power,
    input  logic [15:0] CURRENT_LIMIT,
    input  logic [15:0] VOLTAGE_LIMIT,
    input  logic        ENERGY_CLR,
    output logic        CURRENT_ALARM,
    output logic        VOLTAGE_ALARM,
    output logic        ALL_ALARM,
    output logic        STALE,
    output logic [15:0] KW_HR
);

    localparam int                  c_tick_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam int                  c_stale_w   = (STALE_TICKS > 0) ? $clog2(STALE_TICKS + 1) : 1;
    localparam logic [c_stale_w-1:0] c_stale_max = c_stale_w'(STALE_TICKS);
    localparam logic [c_stale_w-1:0] c_stale_one = c_stale_w'(1);
    localparam logic [39:0]         c_unit      = 40'(UNIT_COUNT);

    logic [c_tick_w-1:0]  r_tick_cnt;
    logic                 w_tick;
    logic [15:0]          r_p_lat;
    logic [39:0]          r_acc;
    logic [15:0]          r_kwh;
    logic [c_stale_w-1:0] r_stale_cnt;
    logic                 w_stale;
    logic [15:0]          w_cur_mag;
    logic                 w_cur_over;
    logic                 w_volt_over;
    logic                 w_cur_alarm;
    logic                 w_volt_alarm;
    logic [15:0]          w_add;
    logic [39:0]          w_acc_sum;

    // ------------------------------------------------------------------
    // Over-limit tests
    // ------------------------------------------------------------------
    // The most negative code has no positive counterpart in 16 bits, so
    // its magnitude is clamped to 32767 instead of wrapping to 0x8000.
    always_comb begin
        w_cur_mag = Current;
        if (Current[15]) begin
            if (Current == 16'h8000) begin
                w_cur_mag = 16'h7FFF;
            end else begin
                w_cur_mag = (~Current) + 16'd1;
            end
        end
    end

    assign w_cur_over  = (CURRENT_LIMIT != 16'd0) && (w_cur_mag > CURRENT_LIMIT);
    assign w_volt_over = (VOLTAGE_LIMIT != 16'd0) && (Bus_Voltage > VOLTAGE_LIMIT);

    power_energy_alarm_chan #(
        .ALARM_COUNT (ALARM_COUNT)
    ) u_cur_chan (
        .clk      (CLK_24),
        .rst      (RESET),
        .i_strobe (SAMPLE_STB),
        .i_over   (w_cur_over),
        .o_alarm  (w_cur_alarm)
    );

    power_energy_alarm_chan #(
        .ALARM_COUNT (ALARM_COUNT)
    ) u_volt_chan (
        .clk      (CLK_24),
        .rst      (RESET),
        .i_strobe (SAMPLE_STB),
        .i_over   (w_volt_over),
        .o_alarm  (w_volt_alarm)
    );

    // ------------------------------------------------------------------
    // Integration tick
    // ------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge CLK_24) begin
        if (RESET) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_one;
        end
    end

    // ------------------------------------------------------------------
    // Stale detection: a strobe always wins over a coincident tick.
    // ------------------------------------------------------------------
    assign w_stale = (r_stale_cnt == c_stale_max);

    always_ff @(posedge CLK_24) begin
        if (RESET) begin
            r_stale_cnt <= '0;
        end else if (SAMPLE_STB) begin
            r_stale_cnt <= '0;
        end else if (w_tick && !w_stale) begin
            r_stale_cnt <= r_stale_cnt + c_stale_one;
        end
    end

    // ------------------------------------------------------------------
    // Energy path. A tick coinciding with a strobe integrates the old
    // latched power; the new sample is used from the following tick.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_24) begin
        if (RESET) begin
            r_p_lat <= 16'd0;
        end else if (SAMPLE_STB) begin
            r_p_lat <= Power;
        end
    end

    assign w_add     = w_stale ? 16'd0 : r_p_lat;
    assign w_acc_sum = r_acc + {24'd0, w_add};

    // At most one unit is removed per tick because a single addend is
    // always smaller than UNIT_COUNT. The accumulator keeps running while
    // KW_HR is pinned at full scale.
    always_ff @(posedge CLK_24) begin
        if (RESET) begin
            r_acc <= 40'd0;
            r_kwh <= 16'd0;
        end else if (ENERGY_CLR) begin
            r_acc <= 40'd0;
            r_kwh <= 16'd0;
        end else if (w_tick) begin
            if (w_acc_sum >= c_unit) begin
                r_acc <= w_acc_sum - c_unit;
                if (r_kwh != 16'hFFFF) begin
                    r_kwh <= r_kwh + 16'd1;
                end
            end else begin
                r_acc <= w_acc_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign CURRENT_ALARM = w_cur_alarm;
    assign VOLTAGE_ALARM = w_volt_alarm;
    assign STALE         = w_stale;
    assign ALL_ALARM     = w_cur_alarm | w_volt_alarm | w_stale;
    assign KW_HR         = r_kwh;

endmodule
`default_nettype wire

// File: tb/tb_power_energy_alarm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_power_energy_alarm
//  Purpose  : Directed self-checking bench for power_energy_alarm. A second
//             instance with a one-cycle tick drives KW_HR into saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_power_energy_alarm;

    logic        CLK_24        = 1'b0;
    logic        RESET         = 1'b1;
    logic        SAMPLE_STB    = 1'b0;
    logic [15:0] Bus_Voltage   = 16'd0;
    logic [15:0] Current       = 16'd0;
    logic [15:0] Power         = 16'd0;
    logic [15:0] CURRENT_LIMIT = 16'd0;
    logic [15:0] VOLTAGE_LIMIT = 16'd0;
    logic        ENERGY_CLR    = 1'b0;
    logic        CURRENT_ALARM;
    logic        VOLTAGE_ALARM;
    logic        ALL_ALARM;
    logic        STALE;
    logic [15:0] KW_HR;

    // saturation instance
    logic        rst2  = 1'b1;
    logic        stb2  = 1'b0;
    logic [15:0] pwr2  = 16'd0;
    logic        cur_alarm2;
    logic        volt_alarm2;
    logic        all_alarm2;
    logic        stale2;
    logic [15:0] kwh2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK_24 = ~CLK_24;

    power_energy_alarm #(
        .TICK_DIV    (10),
        .UNIT_COUNT  (100),
        .ALARM_COUNT (3),
        .STALE_TICKS (3)
    ) dut (
        .CLK_24        (CLK_24),
        .RESET         (RESET),
        .SAMPLE_STB    (SAMPLE_STB),
        .Bus_Voltage   (Bus_Voltage),
        .Current       (Current),
        .Power         (Power),
        .CURRENT_LIMIT (CURRENT_LIMIT),
        .VOLTAGE_LIMIT (VOLTAGE_LIMIT),
        .ENERGY_CLR    (ENERGY_CLR),
        .CURRENT_ALARM (CURRENT_ALARM),
        .VOLTAGE_ALARM (VOLTAGE_ALARM),
        .ALL_ALARM     (ALL_ALARM),
        .STALE         (STALE),
        .KW_HR         (KW_HR)
    );

    power_energy_alarm #(
        .TICK_DIV    (1),
        .UNIT_COUNT  (100),
        .ALARM_COUNT (3),
        .STALE_TICKS (3)
    ) dut2 (
        .CLK_24        (CLK_24),
        .RESET         (rst2),
        .SAMPLE_STB    (stb2),
        .Bus_Voltage   (16'd0),
        .Current       (16'd0),
        .Power         (pwr2),
        .CURRENT_LIMIT (16'd0),
        .VOLTAGE_LIMIT (16'd0),
        .ENERGY_CLR    (1'b0),
        .CURRENT_ALARM (cur_alarm2),
        .VOLTAGE_ALARM (volt_alarm2),
        .ALL_ALARM     (all_alarm2),
        .STALE         (stale2),
        .KW_HR         (kwh2)
    );

    // Leaves the bench #1 after the last reset edge; the next edge is the
    // first active one, and the tenth active edge carries the first tick.
    task automatic do_reset();
        SAMPLE_STB = 1'b0;
        ENERGY_CLR = 1'b0;
        RESET      = 1'b1;
        repeat (2) @(posedge CLK_24);
        #1;
        RESET = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] cur, input logic [15:0] volt, input logic [15:0] pwr);
        Current     = cur;
        Bus_Voltage = volt;
        Power       = pwr;
        SAMPLE_STB  = 1'b1;
        @(posedge CLK_24);
        #1;
        SAMPLE_STB  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (CURRENT_ALARM !== 1'b0) begin n_fail++; $display("FAIL reset_cur_alarm got %b expected 0", CURRENT_ALARM); end
        n_checks++;
        if (VOLTAGE_ALARM !== 1'b0) begin n_fail++; $display("FAIL reset_volt_alarm got %b expected 0", VOLTAGE_ALARM); end
        n_checks++;
        if (ALL_ALARM !== 1'b0) begin n_fail++; $display("FAIL reset_all_alarm got %b expected 0", ALL_ALARM); end
        n_checks++;
        if (STALE !== 1'b0) begin n_fail++; $display("FAIL reset_stale got %b expected 0", STALE); end
        n_checks++;
        if (KW_HR !== 16'd0) begin n_fail++; $display("FAIL reset_kwh got %h expected 0000", KW_HR); end
        n_checks++;
        if (dut.r_acc !== 40'd0) begin n_fail++; $display("FAIL reset_acc got %0d expected 0", dut.r_acc); end
    endtask

    // Strobes on consecutive cycles (back-to-back samples).
    task automatic test_current_debounce();
        logic [15:0] cur   [0:10] = '{16'd1001, 16'd1001, 16'd1001, 16'd500, 16'd500, 16'd500,
                                      16'd1001, 16'd500, 16'd1001, 16'd1001, 16'd500};
        logic        exp_a [0:10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        CURRENT_LIMIT = 16'd1000;
        VOLTAGE_LIMIT = 16'd0;
        for (int i = 0; i < 11; i++) begin
            strobe(cur[i], 16'd0, 16'd0);
            n_checks++;
            if (CURRENT_ALARM !== exp_a[i]) begin n_fail++; $display("FAIL cur_debounce[%0d] CURRENT_ALARM got %b expected %b", i, CURRENT_ALARM, exp_a[i]); end
            n_checks++;
            if (ALL_ALARM !== exp_a[i]) begin n_fail++; $display("FAIL cur_debounce[%0d] ALL_ALARM got %b expected %b", i, ALL_ALARM, exp_a[i]); end
        end
    endtask

    task automatic test_current_boundary();
        logic [15:0] lim   [0:18] = '{16'd32766, 16'd32766, 16'd32766, 16'd32766, 16'd32766, 16'd32766,
                                      16'd1000, 16'd1000, 16'd1000, 16'd1000,
                                      16'd1000, 16'd1000, 16'd1000,
                                      16'd0, 16'd0, 16'd0,
                                      16'd0, 16'd0, 16'd0};
        logic [15:0] cur   [0:18] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000,
                                      16'hFC18, 16'hFC18, 16'hFC18, 16'hFC18,
                                      16'hFC17, 16'hFC17, 16'hFC17,
                                      16'hFC17, 16'hFC17, 16'hFC17,
                                      16'h7FFF, 16'h7FFF, 16'h7FFF};
        logic        exp_a [0:18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                      1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b1,
                                      1'b1, 1'b1, 1'b0,
                                      1'b0, 1'b0, 1'b0};
        VOLTAGE_LIMIT = 16'd0;
        for (int i = 0; i < 19; i++) begin
            CURRENT_LIMIT = lim[i];
            strobe(cur[i], 16'd0, 16'd0);
            n_checks++;
            if (CURRENT_ALARM !== exp_a[i]) begin n_fail++; $display("FAIL cur_boundary[%0d] CURRENT_ALARM got %b expected %b", i, CURRENT_ALARM, exp_a[i]); end
        end
    endtask

    task automatic test_voltage();
        logic [15:0] volt  [0:10] = '{16'd5000, 16'd5000, 16'd5000, 16'd5000, 16'd5000,
                                      16'd5001, 16'd5001, 16'd5001,
                                      16'd4000, 16'd4000, 16'd4000};
        logic        exp_a [0:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b0, 1'b0, 1'b1,
                                      1'b1, 1'b1, 1'b0};
        CURRENT_LIMIT = 16'd0;
        VOLTAGE_LIMIT = 16'd5000;
        for (int i = 0; i < 11; i++) begin
            strobe(16'd0, volt[i], 16'd0);
            n_checks++;
            if (VOLTAGE_ALARM !== exp_a[i]) begin n_fail++; $display("FAIL voltage[%0d] VOLTAGE_ALARM got %b expected %b", i, VOLTAGE_ALARM, exp_a[i]); end
            n_checks++;
            if (CURRENT_ALARM !== 1'b0) begin n_fail++; $display("FAIL voltage[%0d] CURRENT_ALARM got %b expected 0", i, CURRENT_ALARM); end
        end
    endtask

    // Power 30 strobed every 5 cycles; ticks land on active edges 10,20,...
    task automatic test_energy();
        CURRENT_LIMIT = 16'd0;
        VOLTAGE_LIMIT = 16'd0;
        do_reset();
        for (int e = 1; e <= 80; e++) begin
            SAMPLE_STB = ((e % 5) == 1) || (e == 70);
            Power      = (e >= 70) ? 16'd50 : 16'd30;
            ENERGY_CLR = (e == 50);
            @(posedge CLK_24);
            #1;
            SAMPLE_STB = 1'b0;
            ENERGY_CLR = 1'b0;
            if (e == 39) begin
                n_checks++;
                if (KW_HR !== 16'd0) begin n_fail++; $display("FAIL energy_e39_kwh got %0d expected 0", KW_HR); end
                n_checks++;
                if (dut.r_acc !== 40'd90) begin n_fail++; $display("FAIL energy_e39_acc got %0d expected 90", dut.r_acc); end
            end
            if (e == 40) begin
                n_checks++;
                if (KW_HR !== 16'd1) begin n_fail++; $display("FAIL energy_e40_kwh got %0d expected 1", KW_HR); end
                n_checks++;
                if (dut.r_acc !== 40'd20) begin n_fail++; $display("FAIL energy_e40_acc got %0d expected 20", dut.r_acc); end
            end
            if (e == 50) begin
                n_checks++;
                if (KW_HR !== 16'd0) begin n_fail++; $display("FAIL energy_clr_kwh got %0d expected 0", KW_HR); end
                n_checks++;
                if (dut.r_acc !== 40'd0) begin n_fail++; $display("FAIL energy_clr_acc got %0d expected 0", dut.r_acc); end
            end
            if (e == 60) begin
                n_checks++;
                if (dut.r_acc !== 40'd30) begin n_fail++; $display("FAIL energy_after_clr_acc got %0d expected 30", dut.r_acc); end
            end
            if (e == 70) begin
                n_checks++;
                if (dut.r_acc !== 40'd60) begin n_fail++; $display("FAIL energy_stb_tick_acc got %0d expected 60", dut.r_acc); end
            end
            if (e == 80) begin
                n_checks++;
                if (dut.r_acc !== 40'd10) begin n_fail++; $display("FAIL energy_e80_acc got %0d expected 10", dut.r_acc); end
                n_checks++;
                if (KW_HR !== 16'd1) begin n_fail++; $display("FAIL energy_e80_kwh got %0d expected 1", KW_HR); end
                n_checks++;
                if (STALE !== 1'b0) begin n_fail++; $display("FAIL energy_stale got %b expected 0", STALE); end
            end
        end
    endtask

    // One strobe at edge 1, silence until edge 41.
    task automatic test_stale();
        CURRENT_LIMIT = 16'd0;
        VOLTAGE_LIMIT = 16'd0;
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            SAMPLE_STB = (e == 1) || (e == 41);
            Power      = 16'd30;
            @(posedge CLK_24);
            #1;
            SAMPLE_STB = 1'b0;
            if (e == 29) begin
                n_checks++;
                if (STALE !== 1'b0) begin n_fail++; $display("FAIL stale_e29 got %b expected 0", STALE); end
            end
            if (e == 30) begin
                n_checks++;
                if (STALE !== 1'b1) begin n_fail++; $display("FAIL stale_e30 got %b expected 1", STALE); end
                n_checks++;
                if (ALL_ALARM !== 1'b1) begin n_fail++; $display("FAIL stale_all_alarm got %b expected 1", ALL_ALARM); end
                n_checks++;
                if (dut.r_acc !== 40'd90) begin n_fail++; $display("FAIL stale_e30_acc got %0d expected 90", dut.r_acc); end
            end
            if (e == 40) begin
                n_checks++;
                if (dut.r_acc !== 40'd90) begin n_fail++; $display("FAIL stale_acc_frozen got %0d expected 90", dut.r_acc); end
            end
            if (e == 41) begin
                n_checks++;
                if (STALE !== 1'b0) begin n_fail++; $display("FAIL stale_clear got %b expected 0", STALE); end
                n_checks++;
                if (ALL_ALARM !== 1'b0) begin n_fail++; $display("FAIL stale_clear_all got %b expected 0", ALL_ALARM); end
            end
            if (e == 50) begin
                n_checks++;
                if (KW_HR !== 16'd1) begin n_fail++; $display("FAIL stale_resume_kwh got %0d expected 1", KW_HR); end
                n_checks++;
                if (dut.r_acc !== 40'd20) begin n_fail++; $display("FAIL stale_resume_acc got %0d expected 20", dut.r_acc); end
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic exp_a [0:2] = '{1'b0, 1'b0, 1'b1};
        CURRENT_LIMIT = 16'd1000;
        VOLTAGE_LIMIT = 16'd0;
        do_reset();
        strobe(16'd1001, 16'd0, 16'd0);
        strobe(16'd1001, 16'd0, 16'd0);
        n_checks++;
        if (CURRENT_ALARM !== 1'b0) begin n_fail++; $display("FAIL midreset_pre got %b expected 0", CURRENT_ALARM); end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            strobe(16'd1001, 16'd0, 16'd0);
            n_checks++;
            if (CURRENT_ALARM !== exp_a[i]) begin n_fail++; $display("FAIL midreset[%0d] got %b expected %b", i, CURRENT_ALARM, exp_a[i]); end
        end
    endtask

    // Tick every cycle; KW_HR counts edges-1 and should hit FFFF at edge 65536.
    task automatic test_saturation();
        int          hit_at  = 0;
        logic        wrapped = 1'b0;
        logic [15:0] prev    = 16'd0;
        @(posedge CLK_24);
        #1;
        rst2 = 1'b0;
        stb2 = 1'b1;
        pwr2 = 16'hFFFF;
        for (int i = 1; i <= 70000; i++) begin
            @(posedge CLK_24);
            #1;
            if (kwh2 < prev) wrapped = 1'b1;
            prev = kwh2;
            if ((kwh2 == 16'hFFFF) && (hit_at == 0)) hit_at = i;
            if ((hit_at != 0) && (i >= hit_at + 100)) break;
        end
        n_checks++;
        if (hit_at !== 65536) begin n_fail++; $display("FAIL sat_reach_edge got %0d expected 65536", hit_at); end
        n_checks++;
        if (wrapped !== 1'b0) begin n_fail++; $display("FAIL sat_wrap got %b expected 0", wrapped); end
        n_checks++;
        if (kwh2 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h expected ffff", kwh2); end
        stb2 = 1'b0;
        rst2 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_current_debounce();
        test_current_boundary();
        test_voltage();
        test_energy();
        test_stale();
        test_reset_mid_debounce();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/power_energy_alarm.md
Name: power_energy_alarm

Overview:
- Consumer stage placed directly downstream of the I2C power-monitor controller on the motor board.
- Takes each completed Bus_Voltage / Current / Power sample set and raises debounced over-current and over-voltage alarms.
- Integrates Power over time into a saturating kWh counter.
- Drives the board-level ALL_ALARM, CURRENT_ALARM, VOLTAGE_ALARM and KW_HR signals.

Parameters:
- TICK_DIV, 24000000: CLK_24 cycles per 1 s energy-integration tick.
- UNIT_COUNT, 144000000: Power-LSB·seconds per KW_HR increment (25 mW LSB: 3.6e6 Ws / 0.025).
- ALARM_COUNT, 4: consecutive qualifying samples needed to enter or leave an alarm; range 1..15.
- STALE_TICKS, 3: ticks without a sample before the inputs are declared stale.

Ports:
- CLK_24, input, 1: system clock, 24 MHz.
- RESET, input, 1: synchronous reset, active-high.
- SAMPLE_STB, input, 1: one-cycle pulse; Bus_Voltage, Current and Power are valid this cycle.
- Bus_Voltage, input, 16: unsigned bus voltage code.
- Current, input, 16: two's-complement current code.
- Power, input, 16: unsigned power code.
- CURRENT_LIMIT, input, 16: unsigned magnitude limit; 0 disables the current channel.
- VOLTAGE_LIMIT, input, 16: unsigned limit; 0 disables the voltage channel.
- ENERGY_CLR, input, 1: level; clears the accumulator and KW_HR.
- CURRENT_ALARM, output, 1: debounced over-current.
- VOLTAGE_ALARM, output, 1: debounced over-voltage.
- ALL_ALARM, output, 1: CURRENT_ALARM | VOLTAGE_ALARM | STALE.
- STALE, output, 1: no sample seen within STALE_TICKS ticks.
- KW_HR, output, 16: energy count, saturates at 16'hFFFF.

Behaviour:
Clock and reset
- One clock domain (CLK_24). Reset is synchronous and active-high (RESET).
- Reset clears everything: tick counter, accumulator, latched power, stale counter, both channel FSMs (OK, cnt=0), all outputs 0, KW_HR=0.

Channel FSM (two instances)
- Over-test, current channel: mag = |Current|; 16'h8000 gives 32767. Over = (CURRENT_LIMIT != 0) && (mag > CURRENT_LIMIT).
- Over-test, voltage channel: Over = (VOLTAGE_LIMIT != 0) && (Bus_Voltage > VOLTAGE_LIMIT). Equal to limit is not over.
- States: OK, PEND_ON, ALARM, PEND_OFF, with a 4-bit count cnt. The FSM advances only on edges where SAMPLE_STB=1.
- OK: Over -> PEND_ON with cnt=1, or straight to ALARM if ALARM_COUNT==1.
- PEND_ON: Over -> cnt+1, enter ALARM when cnt+1 == ALARM_COUNT. !Over -> OK, cnt=0.
- ALARM: !Over -> PEND_OFF with cnt=1, or straight to OK if ALARM_COUNT==1.
- PEND_OFF: !Over -> cnt+1, enter OK when cnt+1 == ALARM_COUNT. Over -> ALARM, cnt=0.
- Alarm output is 1 in ALARM and PEND_OFF. It is registered and changes on the same rising edge that samples the qualifying strobe (zero added latency).
- A limit changing to 0 takes effect on the next strobe as a !Over sample; no immediate clear.

Energy path
- P_LAT: register loaded from Power on each SAMPLE_STB.
- Tick counter runs 0..TICK_DIV-1 and pulses TICK for one cycle at wrap.
- On TICK: ACC (40-bit) += (STALE ? 0 : P_LAT).
- If the new ACC >= UNIT_COUNT: ACC -= UNIT_COUNT and KW_HR += 1, saturating at FFFF. ACC keeps accumulating when KW_HR is saturated.
- Only one unit is subtracted per tick; this is guaranteed because 65535 < UNIT_COUNT.
- SAMPLE_STB and TICK on the same cycle: the tick adds the old P_LAT; the new value is used from the next tick.
- ENERGY_CLR=1: ACC=0, KW_HR=0, tick counter keeps running. Wins over a simultaneous TICK.

Stale detection
- Stale counter clears on SAMPLE_STB and increments on TICK, saturating at STALE_TICKS.
- STALE = (count == STALE_TICKS).
- A strobe and a tick on the same cycle: the strobe wins, count=0.
- STALE drops on the edge after the next SAMPLE_STB.
- STALE does not reset the channel FSMs.

Mid-operation reset
- RESET asserted mid-debounce returns the FSMs to OK. The partial count is discarded.

Test Plan:
Use TICK_DIV=10, UNIT_COUNT=100, ALARM_COUNT=3, STALE_TICKS=3.
1. Current debounce: CURRENT_LIMIT=1000; strobes with Current=1001,1001,1001.
   - CURRENT_ALARM=1 on the edge of the 3rd strobe; ALL_ALARM=1.
   - Then Current=500 ×3: alarm clears on the 3rd strobe.
   - Pattern 1001,500,1001,1001: alarm stays 0.
2. Negative and boundary current: CURRENT_LIMIT=32766.
   - Current=16'h8000 ×3 -> alarm asserts.
   - Current=16'hFC18 (-1000) with limit 1000 -> never alarms.
   - CURRENT_LIMIT=0 -> never alarms.
3. Voltage equality: VOLTAGE_LIMIT=5000.
   - Bus_Voltage=5000 ×5 -> VOLTAGE_ALARM stays 0.
   - 5001 ×3 -> VOLTAGE_ALARM=1.
4. Energy: Power=30, strobe every 5 cycles, for 4 ticks.
   - KW_HR=1, ACC=20.
   - ENERGY_CLR on a TICK cycle -> KW_HR=0, ACC=0.
5. Saturation: preload path with Power=16'hFFFF, UNIT_COUNT=100 override.
   - KW_HR reaches FFFF and holds there; no wrap.
6. Stale: stop strobes.
   - STALE=1 and ALL_ALARM=1 after the 3rd tick; ACC stops growing.
   - One strobe -> STALE=0 on the next edge.
   - RESET mid-PEND_ON -> the next 2 over samples do not alarm.
